// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the FSM state enum and the counter-width helper.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One partial-product row of the shift-add multiplier.
// Adds (or subtracts, for the signed sign row) a shifted by cnt.
module seq_mult_step
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] a,
  input  logic               b_bit,
  input  logic [CNT_W-1:0]   cnt,
  input  logic               sub,
  output logic [2*WIDTH-1:0] next_acc
);

  logic [2*WIDTH-1:0] w_row;

  assign w_row = a << cnt;

  always_comb begin
    next_acc = acc;
    if (b_bit) begin
      if (sub) next_acc = acc - w_row;
      else     next_acc = acc + w_row;
    end
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier, one row per clock, valid/ready.
// Define MULT_SIGNED_EN to honour sgn_mode (two's complement).
module seq_shift_add_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

`ifdef MULT_SIGNED_EN
  localparam logic SGN_EN = 1'b1;
`else
  localparam logic SGN_EN = 1'b0;
`endif

  mult_state_e        r_state;
  mult_state_e        w_state_nxt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_a;
  logic [WIDTH-1:0]   r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sgn;
  logic [2*WIDTH-1:0] r_product;

  logic               w_sgn_in;
  logic [2*WIDTH-1:0] w_a_ext;
  logic               w_last;
  logic               w_sub;
  logic [2*WIDTH-1:0] w_next_acc;

  assign w_sgn_in = sgn_mode & SGN_EN;
  assign w_a_ext  = w_sgn_in ?
    {{WIDTH{a[WIDTH-1]}}, a} :
    {{WIDTH{1'b0}}, a};
  assign w_last   = (r_cnt == LAST);
  assign w_sub    = r_sgn & w_last;

  seq_mult_step #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step (
    .acc      (r_acc),
    .a        (r_a),
    .b_bit    (r_b[0]),
    .cnt      (r_cnt),
    .sub      (w_sub),
    .next_acc (w_next_acc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // b is consumed LSB-first; r_b[0] is always the current row bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_sgn     <= 1'b0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= w_a_ext;
            r_b   <= b;
            r_sgn <= w_sgn_in;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        BUSY: begin
          r_acc <= w_next_acc;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_product <= w_next_acc;
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult (WIDTH=4 and WIDTH=8).
// Table vectors, random vectors vs. arithmetic model, corner sequences.
module tb_seq_shift_add_mult;

`ifdef MULT_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [3:0] a, b;
  logic       sgn;
  logic       out_valid, out_ready;
  logic [7:0] product;
  logic       busy;

  logic        in_valid8, in_ready8;
  logic [7:0]  a8, b8;
  logic        out_valid8, out_ready8;
  logic [15:0] product8;
  logic        busy8;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sgn_mode  (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  seq_shift_add_mult #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .sgn_mode  (1'b0),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .product   (product8),
    .busy      (busy8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h",
                  nm, got, exp);
  endtask

  function automatic logic [7:0] ref4(
    input logic [3:0] x, input logic [3:0] y,
    input logic s);
    int xi, yi, p;
    xi = int'(x);
    yi = int'(y);
    if (s && SGN) begin
      if (x[3]) xi = xi - 16;
      if (y[3]) yi = yi - 16;
    end
    p = xi * yi;
    return p[7:0];
  endfunction

  task automatic run_op(input logic [3:0] ia,
                        input logic [3:0] ib,
                        input logic is,
                        input int hold,
                        input string nm,
                        input logic [7:0] exp);
    int lat;
    logic [7:0] held;
    chk({nm, " rdy"}, 32'(in_ready), 32'd1);
    a = ia;
    b = ib;
    sgn = is;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    sgn = 1'($urandom);
    chk({nm, " acc"}, {30'd0, in_ready, busy},
        32'b01);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({nm, " lat"}, 32'(lat), 32'd4);
    chk({nm, " prod"}, 32'(product), 32'(exp));
    held = product;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = 4'($urandom);
      tick();
      chk({nm, " hold"},
          {22'd0, out_valid, in_ready, busy,
           held == product, product[3:0]},
          {22'd0, 1'b1, 1'b0, 1'b1, 1'b1,
           exp[3:0]});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, " rel"},
        {29'd0, out_valid, in_ready, busy},
        32'b010);
  endtask

  initial begin
    int cyc, n_acc, n_out;
    int acc_cyc[2];
    int out_cyc[2];
    logic [15:0] outs[2];
    logic sw;
    logic [3:0] ra, rb;
    logic rs;

    vecs[0] = '{4'd15, 4'd15, 1'b0, 8'hE1};
    vecs[1] = '{4'd0,  4'd9,  1'b0, 8'd0};
    vecs[2] = '{4'd9,  4'd0,  1'b0, 8'd0};
    vecs[3] = '{4'd1,  4'd1,  1'b0, 8'd1};
`ifdef MULT_SIGNED_EN
    vecs[4] = '{4'h8, 4'h8, 1'b1, 8'h40};
    vecs[5] = '{4'hF, 4'h7, 1'b1, 8'hF9};
    vecs[6] = '{4'h7, 4'h8, 1'b1, 8'hC8};
`else
    vecs[4] = '{4'h8, 4'h8, 1'b1, 8'd64};
    vecs[5] = '{4'hF, 4'h7, 1'b1, 8'd105};
    vecs[6] = '{4'h7, 4'h8, 1'b1, 8'd56};
`endif
    vecs[7] = '{4'h8, 4'h8, 1'b0, 8'd64};
    vecs[8] = '{4'hF, 4'h7, 1'b0, 8'd105};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sgn = 1'b0;
    in_valid8 = 1'b0;
    out_ready8 = 1'b0;
    a8 = '0;
    b8 = '0;
    tick();
    tick();
    chk("reset", {20'd0, in_ready, out_valid,
                  busy, 1'b0, product},
        {20'd0, 4'b1000, 8'd0});
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].s,
             0, $sformatf("vec%0d", i),
             vecs[i].exp);

    run_op(4'd6, 4'd7, 1'b0, 3, "t3", 8'd42);

    a = 4'd13;
    b = 4'd11;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t4 abort", {20'd0, in_ready, out_valid,
                     busy, 1'b0, product},
        {20'd0, 4'b1000, 8'd0});
    run_op(4'd13, 4'd11, 1'b0, 0, "t4", 8'd143);

    for (int i = 0; i < 20; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, $urandom_range(0, 2),
             $sformatf("rnd%0d", i),
             ref4(ra, rb, rs));
    end

    a8 = 8'd255;
    b8 = 8'd255;
    in_valid8 = 1'b1;
    out_ready8 = 1'b1;
    cyc = 0;
    n_acc = 0;
    n_out = 0;
    sw = 1'b0;
    acc_cyc = '{0, 0};
    out_cyc = '{0, 0};
    outs = '{16'd0, 16'd0};
    for (int i = 0; i < 40; i++) begin
      if (in_ready8 && in_valid8 && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        sw = 1'b1;
      end
      if (out_valid8 && n_out < 2) begin
        outs[n_out] = product8;
        out_cyc[n_out] = cyc;
        n_out++;
      end
      tick();
      cyc++;
      if (sw) begin
        a8 = 8'd128;
        b8 = 8'd2;
        sw = 1'b0;
      end
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b0;
    chk("t6 n_acc", 32'(n_acc), 32'd2);
    chk("t6 n_out", 32'(n_out), 32'd2);
    chk("t6 p0", 32'(outs[0]), 32'hFE01);
    chk("t6 p1", 32'(outs[1]), 32'h0100);
    chk("t6 acc gap", 32'(acc_cyc[1] - acc_cyc[0]),
        32'd10);
    chk("t6 out gap", 32'(out_cyc[1] - out_cyc[0]),
        32'd10);
    chk("t6 lat", 32'(out_cyc[0] - acc_cyc[0]),
        32'd9);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
